// File: rtl/max_argmax_seq_pkg.sv
// -----------------------------------------------------------------------------
// max_argmax_seq_pkg
//   Shared ALU package for the max/argmax reduction controller.
//   Holds the controller FSM state encoding and the default element and
//   length widths.
// -----------------------------------------------------------------------------
package max_argmax_seq_pkg;

   // Reduction controller FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Default data element width and vector length / index width.
   localparam int DEF_LEN   = 8;
   localparam int DEF_CNT_W = 8;

endpackage : max_argmax_seq_pkg

// File: rtl/max_argmax_seq_comp.sv
// -----------------------------------------------------------------------------
// comp
//   ALU magnitude comparator. Purely combinational, unsigned ordering.
//
//   Ports:
//     in1  in  LEN  first operand
//     in2  in  LEN  second operand
//     out  out 1    1 when in1 < in2 (unsigned)
// -----------------------------------------------------------------------------
module comp #(
   parameter int LEN = 8
) (
   input  logic [LEN-1:0] in1,
   input  logic [LEN-1:0] in2,
   output logic           out
);

   assign out = (in1 < in2);

endmodule : comp

// File: rtl/max_argmax_seq.sv
// -----------------------------------------------------------------------------
// max_argmax_seq
//   Sequential max/argmax reduction over a streamed vector. A start command
//   carries the vector length; elements arrive one per cycle over a
//   valid/ready handshake. The running best value and its index are kept
//   and, after the last element, copied to max_out/idx_out while done
//   pulses for one cycle.
//
//   Build option:
//     SIGNED_CMP_EN  when defined, elements are two's complement. Both
//                    comparator operands get their MSB inverted, turning the
//                    unsigned comparator into a signed one. Stored values
//                    stay unbiased.
//
//   Ports:
//     clk        in   1      clock, all state on rising edge
//     reset      in   1      asynchronous, active-high reset
//     start      in   1      command pulse, sampled only in IDLE
//     vec_len    in   CNT_W  element count, sampled with start
//     in_data    in   LEN    stream element
//     in_valid   in   1      in_data valid
//     in_ready   out  1      element accepted this cycle if in_valid
//     max_out    out  LEN    best value of the last completed vector
//     idx_out    out  CNT_W  0-based index of max_out
//     done       out  1      one-cycle result-valid pulse
//     busy       out  1      high in RUN and DONE
//     dbg_state  out  2      current FSM state (debug observation)
//
//   Handshake: an element transfers on a rising edge where in_valid and
//   in_ready are both high; in_valid low is a stall and changes nothing.
// -----------------------------------------------------------------------------
module max_argmax_seq
   import max_argmax_seq_pkg::*;
#(
   parameter int LEN   = DEF_LEN,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] vec_len,
   input  logic [LEN-1:0]   in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [LEN-1:0]   max_out,
   output logic [CNT_W-1:0] idx_out,
   output logic             done,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_count;
   logic [LEN-1:0]   r_best;
   logic [CNT_W-1:0] r_best_idx;
   logic [LEN-1:0]   r_max;
   logic [CNT_W-1:0] r_idx;

   logic [LEN-1:0]   w_cmp_a;
   logic [LEN-1:0]   w_cmp_b;
   logic             w_lt;
   logic             w_accept;
   logic             w_last;
   logic             w_take;

`ifdef SIGNED_CMP_EN
   // Flipping the sign bit maps two's complement order onto unsigned order.
   assign w_cmp_a = {~r_best[LEN-1],  r_best[LEN-2:0]};
   assign w_cmp_b = {~in_data[LEN-1], in_data[LEN-2:0]};
`else
   assign w_cmp_a = r_best;
   assign w_cmp_b = in_data;
`endif

   comp #(.LEN(LEN)) u_comp (
      .in1 (w_cmp_a),
      .in2 (w_cmp_b),
      .out (w_lt)
   );

   assign w_accept = (r_state == ST_RUN) && in_valid;
   assign w_last   = (r_count == (r_len - CNT_W'(1)));
   // First element always loads; later ones only when strictly greater,
   // so ties keep the earlier index.
   assign w_take   = (r_count == '0) || w_lt;

   // Outputs decode straight from state so reset clears them at once.
   assign in_ready  = (r_state == ST_RUN);
   assign done      = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign max_out   = r_max;
   assign idx_out   = r_idx;
   assign dbg_state = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = (vec_len != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            if (w_accept && w_last) w_next_state = ST_DONE;
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len      <= '0;
         r_count    <= '0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_max      <= '0;
         r_idx      <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         if (vec_len != '0) begin
            r_len   <= vec_len;
            r_count <= '0;
         end else begin
            r_max <= '0;
            r_idx <= '0;
         end
      end else if (w_accept) begin
         r_count <= r_count + CNT_W'(1);
         if (w_take) begin
            r_best     <= in_data;
            r_best_idx <= r_count;
         end
         if (w_last) begin
            r_max <= w_take ? in_data : r_best;
            r_idx <= w_take ? r_count : r_best_idx;
         end
      end
   end

endmodule : max_argmax_seq

// File: doc/max_argmax_seq.md
# max_argmax_seq

Sequential max/argmax reduction controller that drives one instance of the team's ALU magnitude comparator over a streamed vector. It accepts a start command with a vector length, consumes one element per cycle over a valid/ready handshake, and keeps a running best value and its index. When the vector ends it pulses `done` and holds the result. It sits beside the ALU lanes and serves reductions such as classification output selection.

## Interface
- `LEN`, 8, data element width in bits
- `CNT_W`, 8, width of vector length and index; max vector length 2^CNT_W − 1

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  command pulse; sampled only in IDLE
- `vec_len`  in  CNT_W  element count, sampled with `start`
- `in_data`  in  LEN  stream element
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts an element this cycle
- `max_out`  out  LEN  best value of the last completed vector
- `idx_out`  out  CNT_W  index (0-based) of `max_out`
- `done`  out  1  one-cycle pulse: result valid
- `busy`  out  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=0, `busy`=0.
  - `start`=1 with `vec_len`≠0: latch `vec_len`, clear `count`, go to RUN.
  - `start`=1 with `vec_len`=0: set `max_out`=0 and `idx_out`=0, go to DONE.
- RUN:
  - `in_ready`=1. Accept an element on `in_valid`&`in_ready`.
  - `count`=0: load best=`in_data`, best_idx=0.
  - Otherwise the comparator gets in1=best and in2=`in_data`. Its output is 1 when best < `in_data`; then load best=`in_data` and best_idx=`count`.
  - Ties keep the earlier index.
  - Each accept increments `count`. The accept with `count`=latched_len−1 copies the final best into `max_out`/`idx_out` and goes to DONE.
  - Cycles with `in_valid`=0 are stalls. State is unchanged.
- DONE: `done`=1 for exactly one cycle, `in_ready`=0, then IDLE.
- `max_out`/`idx_out` hold until the next completion. They are not disturbed by `start` or by a RUN in progress.
- `start` in RUN or DONE is ignored. There is no abort; only `reset` aborts.
- `count` never wraps, because latched_len ≤ 2^CNT_W − 1.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `done`=0, `busy`=0, `max_out`=0, `idx_out`=0, internal best/count=0.
- `reset` asserted mid-RUN: outputs return to reset values immediately (asynchronously). The partial result is discarded.
- `start` at cycle t: RUN at t+1, so `in_ready`=1 from t+1.
- Last element accepted at cycle t: `done`=1 at t+1 with `max_out`/`idx_out` valid. The block is in IDLE at t+2 and can take `start` at t+2.
- Zero-length command at t: `done` at t+1.
- Throughput: 1 element/cycle with no stalls. Vector of N elements: `start`→`done` = N+1 cycles.
- Comparator path is combinational within one cycle; there are no pipeline bubbles.

## Configuration
- `SIGNED_CMP_EN` defined:
  - Elements are two's complement.
  - The MSB of both comparator operands is inverted before the unsigned comparator, giving signed ordering.
  - `max_out` holds the original (unbiased) value.
- Undefined: elements are unsigned and the comparator is driven directly.

## Structure
- Shared ALU package holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the default `LEN`/`CNT_W` constants.
- One sub-module: the existing ALU comparator `comp`, instantiated once with `LEN`. No other hierarchy.

## Test plan
- Unsigned, `vec_len`=4, stream 3,9,2,7 with no stalls → `done` 5 cycles after `start`, `max_out`=9, `idx_out`=1.
- Ties, stream 5,8,8,1 → `idx_out`=1 (first occurrence kept).
- `vec_len`=0 → `done` next cycle, `max_out`=0, `idx_out`=0, no `in_ready` pulse.
- `vec_len`=3 with `in_valid` gaps of 2 cycles, plus `start` pulsed during RUN → result correct, extra `start` ignored, `busy` continuous.
- `reset` asserted after 2 of 5 elements → outputs 0 at once. A new 2-element run of 4,6 then gives `max_out`=6, `idx_out`=1.
- `SIGNED_CMP_EN` with LEN=8, stream 0xFE(−2),0x03,0x80(−128) → `max_out`=0x03, `idx_out`=1. Without the macro → `max_out`=0xFE, `idx_out`=0.
